// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: EX branch types and FSM states.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    BT_NONE = 2'b00,
    BT_BEQ  = 2'b01,
    BT_BNE  = 2'b10,
    BT_JUMP = 2'b11
  } branch_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hcu_state_e;

  localparam int HOLD_CNT_W = 3;

endpackage

// File: rtl/hazard_control_unit_match.sv
// Load-use detector: flags a load in EX whose destination feeds a used ID source operand.
module hazard_match
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
) (
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_rs,
  input  logic [NUM_SRC-1:0]            i_id_rs_used,
  input  logic [REG_ADDR_W-1:0]         i_ex_rd,
  input  logic                          i_ex_memread,
  output logic                          o_load_use
);

  logic w_hit;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_id_rs_used[i] && (i_id_rs[i*REG_ADDR_W +: REG_ADDR_W] == i_ex_rd)) begin
        w_hit = 1'b1;
      end
    end
  end

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign o_load_use = i_ex_memread && (i_ex_rd != '0) && w_hit;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, and a saturating hazard-cycle counter.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_memread,
  input  logic [1:0]                    ex_branch_type,
  input  logic                          ex_zero,
  output logic                          pc_write_en,
  output logic                          ifid_write_en,
  output logic                          idex_bubble,
  output logic                          ifid_flush,
  output logic                          branch_taken,
  output logic [CNT_W-1:0]              hazard_cycles
);

  localparam logic [HOLD_CNT_W-1:0] STALL_RELOAD = HOLD_CNT_W'(LOAD_STALL - 1);
  localparam logic [HOLD_CNT_W-1:0] FLUSH_RELOAD = HOLD_CNT_W'(FLUSH_CYCLES - 1);

  hcu_state_e            r_state;
  hcu_state_e            w_state_nxt;
  logic [HOLD_CNT_W-1:0] r_cnt;
  logic [HOLD_CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0]      r_hazard_cycles;

  logic w_load_use;
  logic w_take;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_bubble;
  logic w_flush;
  logic w_taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC)
  ) u_hazard_match (
    .i_id_rs      (id_rs),
    .i_id_rs_used (id_rs_used),
    .i_ex_rd      (ex_rd),
    .i_ex_memread (ex_memread),
    .o_load_use   (w_load_use)
  );

  assign w_take = ((ex_branch_type == BT_BEQ) &&  ex_zero) ||
                  ((ex_branch_type == BT_BNE) && !ex_zero) ||
                   (ex_branch_type == BT_JUMP);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_we     = 1'b1;
    w_ifid_we   = 1'b1;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_taken     = 1'b0;
    case (r_state)
      ST_IDLE, ST_STALL: begin
        // A taken branch squashes the dependent instruction, so it overrides any stall.
        if (w_take) begin
          w_taken = 1'b1;
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = FLUSH_RELOAD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else if (r_state == ST_STALL) begin
          w_pc_we   = 1'b0;
          w_ifid_we = 1'b0;
          w_bubble  = 1'b1;
          w_cnt_nxt = r_cnt - HOLD_CNT_W'(1);
          if (r_cnt <= HOLD_CNT_W'(1)) w_state_nxt = ST_IDLE;
        end else if (w_load_use) begin
          w_pc_we   = 1'b0;
          w_ifid_we = 1'b0;
          w_bubble  = 1'b1;
          if (LOAD_STALL > 1) begin
            w_state_nxt = ST_STALL;
            w_cnt_nxt   = STALL_RELOAD;
          end
        end
      end
      ST_FLUSH: begin
        w_flush   = 1'b1;
        w_cnt_nxt = r_cnt - HOLD_CNT_W'(1);
        if (r_cnt <= HOLD_CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_hazard_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!w_pc_we || w_flush) r_hazard_cycles <= sat_inc(r_hazard_cycles);
    end
  end

  assign pc_write_en   = w_pc_we;
  assign ifid_write_en = w_ifid_we;
  assign idex_bubble   = w_bubble;
  assign ifid_flush    = w_flush;
  assign branch_taken  = w_taken;
  assign hazard_cycles = r_hazard_cycles;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances (1-cycle stall, 3-cycle stall, 2-bit counter) share stimulus.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  logic        clock;
  logic        reset;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic [1:0]  ex_branch_type;
  logic        ex_zero;

  logic        pcw1, ifw1, bub1, fl1, bt1;
  logic [15:0] hc1;
  logic        pcw3, ifw3, bub3, fl3, bt3;
  logic [15:0] hc3;
  logic        pcws, ifws, bubs, fls, bts;
  logic [1:0]  hcs;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_control_unit #(.LOAD_STALL(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut_s1 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_type(ex_branch_type), .ex_zero(ex_zero),
    .pc_write_en(pcw1), .ifid_write_en(ifw1), .idex_bubble(bub1), .ifid_flush(fl1),
    .branch_taken(bt1), .hazard_cycles(hc1));

  hazard_control_unit #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut_s3 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_type(ex_branch_type), .ex_zero(ex_zero),
    .pc_write_en(pcw3), .ifid_write_en(ifw3), .idex_bubble(bub3), .ifid_flush(fl3),
    .branch_taken(bt3), .hazard_cycles(hc3));

  hazard_control_unit #(.LOAD_STALL(1), .FLUSH_CYCLES(2), .CNT_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_type(ex_branch_type), .ex_zero(ex_zero),
    .pc_write_en(pcws), .ifid_write_en(ifws), .idex_bubble(bubs), .ifid_flush(fls),
    .branch_taken(bts), .hazard_cycles(hcs));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge and let them settle before checking.
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs2,
                       input logic [4:0] rs1, input logic [1:0] used,
                       input logic [1:0] bt, input logic zero);
    ex_memread     = mr;
    ex_rd          = rd;
    id_rs          = {rs2, rs1};
    id_rs_used     = used;
    ex_branch_type = bt;
    ex_zero        = zero;
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, BT_NONE, 1'b0);
  endtask

  task automatic load_in();
    drive(1'b1, 5'd5, 5'd5, 5'd3, 2'b11, BT_NONE, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_in();
    cyc();
    cyc();
    chk("rst_pcw", pcw1, 1);
    chk("rst_ifw", ifw1, 1);
    chk("rst_bub", bub1, 0);
    chk("rst_flush", fl1, 0);
    chk("rst_taken", bt1, 0);
    chk("rst_hc", hc1, 0);
    reset = 1'b0;
    cyc();

    // Load-use with both operands used; rs2 matches ex_rd.
    load_in();
    chk("lu1_pcw", pcw1, 0);
    chk("lu1_ifw", ifw1, 0);
    chk("lu1_bub", bub1, 1);
    chk("lu3_c1_pcw", pcw3, 0);
    cyc();
    idle_in();
    chk("lu1_after_pcw", pcw1, 1);
    chk("lu1_after_bub", bub1, 0);
    chk("lu1_hc", hc1, 1);
    chk("lu3_c2_pcw", pcw3, 0);
    chk("lu3_c2_bub", bub3, 1);
    cyc();
    idle_in();
    chk("lu3_c3_pcw", pcw3, 0);
    cyc();
    idle_in();
    chk("lu3_done_pcw", pcw3, 1);
    chk("lu3_done_bub", bub3, 0);
    chk("lu3_hc", hc3, 3);

    // Matches that must not stall.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 2'b11, BT_NONE, 1'b0);
    chk("rd0_pcw1", pcw1, 1);
    chk("rd0_pcw3", pcw3, 1);
    drive(1'b1, 5'd5, 5'd5, 5'd5, 2'b00, BT_NONE, 1'b0);
    chk("unused_pcw1", pcw1, 1);
    chk("unused_bub3", bub3, 0);
    drive(1'b0, 5'd5, 5'd5, 5'd5, 2'b11, BT_NONE, 1'b0);
    chk("noload_pcw1", pcw1, 1);
    cyc();
    idle_in();
    chk("nostall_hc1", hc1, 1);

    // BEQ taken: one cycle of branch_taken, two cycles of flush.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, BT_BEQ, 1'b1);
    chk("beq_taken", bt1, 1);
    chk("beq_flush_c1", fl1, 1);
    chk("beq_pcw", pcw1, 1);
    cyc();
    idle_in();
    chk("beq_taken_c2", bt1, 0);
    chk("beq_flush_c2", fl1, 1);
    cyc();
    idle_in();
    chk("beq_flush_c3", fl1, 0);
    chk("beq_hc", hc1, 3);

    // Not-taken conditional branches.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, BT_BNE, 1'b1);
    chk("bne_nt_taken", bt1, 0);
    chk("bne_nt_flush", fl1, 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, BT_BEQ, 1'b0);
    chk("beq_nt_taken", bt1, 0);
    cyc();

    // JUMP together with a load-use: flush wins, no stall.
    drive(1'b1, 5'd5, 5'd5, 5'd3, 2'b11, BT_JUMP, 1'b0);
    chk("jlu_taken", bt1, 1);
    chk("jlu_flush", fl1, 1);
    chk("jlu_pcw1", pcw1, 1);
    chk("jlu_bub1", bub1, 0);
    chk("jlu_pcw3", pcw3, 1);
    cyc();
    load_in();
    chk("jlu_c2_flush", fl3, 1);
    chk("jlu_c2_pcw3", pcw3, 1);
    cyc();
    idle_in();
    chk("jlu_c3_flush", fl1, 0);
    chk("jlu_hc1", hc1, 5);
    chk("jlu_hc3", hc3, 7);

    // Take arriving in the second of three stall cycles.
    load_in();
    chk("tis_c1_pcw3", pcw3, 0);
    cyc();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, BT_JUMP, 1'b0);
    chk("tis_c2_taken", bt3, 1);
    chk("tis_c2_flush", fl3, 1);
    chk("tis_c2_pcw3", pcw3, 1);
    chk("tis_c2_bub3", bub3, 0);
    cyc();
    idle_in();
    chk("tis_c3_flush", fl3, 1);
    chk("tis_c3_taken", bt3, 0);
    cyc();
    idle_in();
    chk("tis_c4_flush", fl3, 0);
    chk("tis_c4_pcw3", pcw3, 1);
    chk("tis_hc3", hc3, 10);
    chk("tis_hc1", hc1, 8);
    chk("sat_early", hcs, 3);

    // Asynchronous reset in the middle of a stall.
    load_in();
    cyc();
    idle_in();
    chk("rms_pre_pcw3", pcw3, 0);
    reset = 1'b1;
    #1;
    chk("rms_pcw3", pcw3, 1);
    chk("rms_ifw3", ifw3, 1);
    chk("rms_bub3", bub3, 0);
    chk("rms_hc3", hc3, 0);
    chk("rms_hcs", hcs, 0);
    cyc();
    reset = 1'b0;
    idle_in();
    chk("rel_pcw3", pcw3, 1);
    chk("rel_hc3", hc3, 0);
    cyc();
    idle_in();
    chk("rel_c2_pcw3", pcw3, 1);
    chk("rel_c2_flush3", fl3, 0);

    // Five one-cycle hazards into a 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      load_in();
      cyc();
    end
    idle_in();
    chk("sat_hcs", hcs, 3);
    chk("sat_hc1", hc1, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised pipeline hazard controller for the processor core. Detects load-use data hazards by comparing the EX-stage destination register against the ID-stage source registers, and resolves branches and jumps into a control-flow flush. A small FSM holds stalls and flushes for a configurable number of cycles and drives the PC, IF/ID and ID/EX pipeline-register controls. A saturating counter records hazard cycles for performance debug.

## Interface
Parameters:
- REG_ADDR_W, 5: register address width.
- NUM_SRC, 2: number of ID-stage source operands compared.
- LOAD_STALL, 1: bubble cycles per load-use hazard, range 1..7.
- FLUSH_CYCLES, 2: cycles IF/ID is flushed after a taken branch or jump, range 1..7.
- CNT_W, 16: width of the stall/flush cycle counter.

Ports:
- clock  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  NUM_SRC*REG_ADDR_W  ID source register addresses; operand i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_rs_used  in  NUM_SRC  per-operand valid; an unused operand never causes a hazard.
- ex_rd  in  REG_ADDR_W  EX-stage destination register.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_type  in  2  encoding: 00 none, 01 BEQ, 10 BNE, 11 JUMP.
- ex_zero  in  1  ALU zero flag for the EX instruction.
- pc_write_en  out  1  PC may update.
- ifid_write_en  out  1  IF/ID register may update.
- idex_bubble  out  1  insert a NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID to a NOP.
- branch_taken  out  1  PC selects the branch/jump target this cycle.
- hazard_cycles  out  CNT_W  saturating count of STALL plus FLUSH cycles.

## Operation
- load_use = ex_memread and ex_rd != 0 and, for some operand i, id_rs_used[i] and id_rs[i] == ex_rd.
- take = (type 01 and ex_zero) or (type 10 and not ex_zero) or (type 11).
- FSM states: IDLE, STALL, FLUSH. A down-counter holds the remaining cycles, 3 bits wide.
- IDLE:
  - take: assert branch_taken and ifid_flush this cycle. If FLUSH_CYCLES > 1, go to FLUSH with count = FLUSH_CYCLES-1.
  - else load_use: deassert pc_write_en and ifid_write_en, and assert idex_bubble this cycle. If LOAD_STALL > 1, go to STALL with count = LOAD_STALL-1.
  - else: pass-through, with pc_write_en = ifid_write_en = 1 and all other outputs 0.
- STALL: hold the stall outputs. Decrement the counter; return to IDLE when it reaches 0 after that cycle.
- FLUSH: assert ifid_flush and keep branch_taken at 0. Decrement; return to IDLE at 0.
- Priority: take beats load_use in every state, because a taken branch kills the dependent instruction.
  - A take arriving in STALL aborts the stall and enters the IDLE-take behaviour that same cycle.
  - A load_use arriving in FLUSH is ignored.
- hazard_cycles increments on every cycle in which pc_write_en = 0 or ifid_flush = 1. It saturates at all-ones.

## Timing
- Decode is Mealy in IDLE: outputs respond combinationally in the same cycle as the hazard inputs. Follow-on cycles are Moore, decoded from the registered state.
- Load-use costs exactly LOAD_STALL cycles of pc_write_en = 0. A taken branch costs exactly FLUSH_CYCLES cycles of ifid_flush = 1.
- branch_taken is high for exactly one cycle per taken branch.
- Reset values: state IDLE, counter 0, hazard_cycles 0. Outputs: pc_write_en = 1, ifid_write_en = 1, all other outputs 0.
- Reset mid-STALL or mid-FLUSH returns to IDLE asynchronously. No residual stall or flush appears after reset is released.
- Combinational outputs with state == IDLE are still evaluated during reset, but the pipeline is held in reset, so this is harmless.

## Structure
- Shared package: the branch-type encodings (BT_NONE, BT_BEQ, BT_BNE, BT_JUMP) and the FSM state encoding. These are reused by the control unit and the bench.
- One natural sub-module: hazard_match. It is purely combinational, takes NUM_SRC address compares, and outputs load_use. It is instantiated once.
- The FSM, the down-counter and the saturating counter live in the top module.

## Test plan
- LOAD_STALL=1: ex_memread=1, ex_rd=5, id_rs={rs2=5, rs1=3}, both used. Required: exactly 1 cycle with pc_write_en=0 and idex_bubble=1, then pass-through; hazard_cycles=1.
- LOAD_STALL=3: same hazard, inputs held for 1 cycle. Required: 3 consecutive stall cycles, then IDLE.
- ex_rd=0 or id_rs_used=0 on a match. Required: no stall.
- Branch test: BEQ with ex_zero=1, FLUSH_CYCLES=2. Required: branch_taken high for 1 cycle and ifid_flush high for 2 cycles.
  - BNE with ex_zero=1: not taken, no flush.
- JUMP and load_use in the same cycle. Required: flush only, no stall.
  - Take arriving during STALL cycle 2 of 3: stall aborted, flush begins that cycle.
- Reset asserted in STALL cycle 2. Required: outputs return to reset values immediately.
  - After release: pass-through with hazard_cycles=0.
  - Saturation check with CNT_W=2: 5 hazard cycles leaves the counter at 3.
